// File: rtl/icache_assoc_pkg.sv
// Shared types and address-split width helpers for the set-associative instruction cache.
// Pure declarations: no logic, no timing.
package icache_pkg;

  typedef enum logic [1:0] {
    IDLE,
    MEM_READ,
    REFILL
  } state_e;

  function automatic int OFF_BITS(input int block_words);
    return $clog2(block_words * 4);
  endfunction

  function automatic int IDX_BITS(input int sets);
    return $clog2(sets);
  endfunction

  function automatic int TAG_BITS(input int addr_width, input int block_words, input int sets);
    return addr_width - OFF_BITS(block_words) - IDX_BITS(sets);
  endfunction

endpackage

// File: rtl/icache_assoc_if.sv
// CPU fetch and block-memory refill signals of the instruction cache, grouped in one bundle.
// master = CPU/memory side, slave = cache side.
interface icache_assoc_if #(
  parameter int ADDR_WIDTH  = 10,
  parameter int BLOCK_WORDS = 4
);
  import icache_pkg::*;

  localparam int BA_W = ADDR_WIDTH - OFF_BITS(BLOCK_WORDS);

  logic                      readen;
  logic [ADDR_WIDTH-1:0]     inaddress;
  logic [31:0]               readword;
  logic                      busycache;
  logic                      flush;
  logic                      read;
  logic [BA_W-1:0]           addressmem;
  logic [BLOCK_WORDS*32-1:0] readmemdata;
  logic                      busymem;

  modport master (
    output readen, inaddress, flush, readmemdata, busymem,
    input  readword, busycache, read, addressmem
  );

  modport slave (
    input  readen, inaddress, flush, readmemdata, busymem,
    output readword, busycache, read, addressmem
  );

endinterface

// File: rtl/icache_assoc_way_array.sv
// One cache way: per-set block data, tag and valid bit; combinational read, write and
// invalidate-all take effect at the clock edge.
module icache_way_array
  import icache_pkg::*;
#(
  parameter int BLOCK_WORDS = 4,
  parameter int SETS        = 8,
  parameter int TAG_W       = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [IDX_BITS(SETS)-1:0]   rd_idx,
  output logic                        rd_vld,
  output logic [TAG_W-1:0]            rd_tag,
  output logic [BLOCK_WORDS*32-1:0]   rd_data,
  input  logic                        wr_en,
  input  logic [IDX_BITS(SETS)-1:0]   wr_idx,
  input  logic [TAG_W-1:0]            wr_tag,
  input  logic [BLOCK_WORDS*32-1:0]   wr_data,
  input  logic                        flush,
  output logic [SETS-1:0]             valid_o
);

  logic [SETS-1:0]           valid_q, valid_d;
  logic [TAG_W-1:0]          tag_q  [SETS];
  logic [TAG_W-1:0]          tag_d  [SETS];
  logic [BLOCK_WORDS*32-1:0] data_q [SETS];
  logic [BLOCK_WORDS*32-1:0] data_d [SETS];

  always_comb begin
    valid_d = valid_q;
    tag_d   = tag_q;
    data_d  = data_q;
    if (wr_en) begin
      valid_d[wr_idx] = 1'b1;
      tag_d[wr_idx]   = wr_tag;
      data_d[wr_idx]  = wr_data;
    end
    if (flush) begin
      valid_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
    end else begin
      valid_q <= valid_d;
    end
  end

  // Payload needs no reset: it is only ever observed through a set valid bit.
  always_ff @(posedge clk) begin
    tag_q  <= tag_d;
    data_q <= data_d;
  end

  assign rd_vld  = valid_q[rd_idx];
  assign rd_tag  = tag_q[rd_idx];
  assign rd_data = data_q[rd_idx];
  assign valid_o = valid_q;

endmodule

// File: rtl/icache_assoc.sv
// N-way (1 or 2) set-associative instruction cache: hits return in the same cycle,
// a miss stalls the CPU for memory latency + 2 cycles while the block is refilled.
module icache_assoc
  import icache_pkg::*;
#(
  parameter int ADDR_WIDTH  = 10,
  parameter int WORD_WIDTH  = 32,
  parameter int BLOCK_WORDS = 4,
  parameter int SETS        = 8,
  parameter int WAYS        = 2
) (
  input logic           clk,
  input logic           rst,
  icache_assoc_if.slave bus
);

  localparam int OFF_W  = OFF_BITS(BLOCK_WORDS);
  localparam int IDX_W  = IDX_BITS(SETS);
  localparam int TAG_W  = TAG_BITS(ADDR_WIDTH, BLOCK_WORDS, SETS);
  localparam int BA_W   = ADDR_WIDTH - OFF_W;
  localparam int WSEL_W = OFF_W - 2;

  logic [IDX_W-1:0]  idx;
  logic [TAG_W-1:0]  tag;
  logic [WSEL_W-1:0] wsel;
  logic              unused_lo;

  assign idx       = bus.inaddress[OFF_W +: IDX_W];
  assign tag       = bus.inaddress[ADDR_WIDTH-1 -: TAG_W];
  assign wsel      = bus.inaddress[2 +: WSEL_W];
  assign unused_lo = ^bus.inaddress[1:0];

  state_e                state_q, state_d;
  logic [BA_W-1:0]       baddr_q, baddr_d;
  logic                  drop_q, drop_d;
  logic [WORD_WIDTH-1:0] rword_q, rword_d;
  logic [SETS-1:0]       lru_q, lru_d;

  logic [IDX_W-1:0] fill_idx;
  logic [TAG_W-1:0] fill_tag;
  assign fill_idx = baddr_q[IDX_W-1:0];
  assign fill_tag = baddr_q[BA_W-1:IDX_W];

  logic [WAYS-1:0]                                   way_hit, way_we, way_rvld;
  logic [WAYS-1:0][SETS-1:0]                         way_valid;
  logic [WAYS-1:0][TAG_W-1:0]                        way_tag;
  logic [WAYS-1:0][BLOCK_WORDS-1:0][WORD_WIDTH-1:0]  way_data;

  logic                                 lookup, hit, hit_way, victim, install, busy, rd_req;
  logic [BLOCK_WORDS-1:0][WORD_WIDTH-1:0] hit_blk;
  logic [WORD_WIDTH-1:0]                hit_word;

  for (genvar w = 0; w < WAYS; w++) begin : g_way
    icache_way_array #(
      .BLOCK_WORDS(BLOCK_WORDS),
      .SETS       (SETS),
      .TAG_W      (TAG_W)
    ) u_way (
      .clk    (clk),
      .rst    (rst),
      .rd_idx (idx),
      .rd_vld (way_rvld[w]),
      .rd_tag (way_tag[w]),
      .rd_data(way_data[w]),
      .wr_en  (way_we[w]),
      .wr_idx (fill_idx),
      .wr_tag (fill_tag),
      .wr_data(bus.readmemdata),
      .flush  (bus.flush),
      .valid_o(way_valid[w])
    );
    assign way_hit[w] = way_rvld[w] && (way_tag[w] == tag);
    assign way_we[w]  = install && (int'(victim) == w);
  end

  assign lookup = (state_q == IDLE) && bus.readen;
  assign hit    = lookup && (|way_hit);

  always_comb begin
    hit_way = 1'b0;
    hit_blk = way_data[0];
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (way_hit[w]) begin
        hit_way = w[0];
        hit_blk = way_data[w];
      end
    end
  end

  assign hit_word = hit_blk[wsel];

  // Fill the lowest-numbered empty way first; only a full set consults the LRU bit.
  always_comb begin
    victim = (WAYS > 1) ? lru_q[fill_idx] : 1'b0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!way_valid[w][fill_idx]) begin
        victim = w[0];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    baddr_d = baddr_q;
    drop_d  = drop_q;
    rword_d = rword_q;
    lru_d   = lru_q;
    install = 1'b0;
    busy    = 1'b0;
    rd_req  = 1'b0;
    case (state_q)
      IDLE: begin
        if (hit) begin
          rword_d    = hit_word;
          lru_d[idx] = ~hit_way;
        end else if (lookup) begin
          busy    = 1'b1;
          baddr_d = bus.inaddress[ADDR_WIDTH-1:OFF_W];
          state_d = MEM_READ;
        end
      end
      MEM_READ: begin
        rd_req = 1'b1;
        busy   = 1'b1;
        if (bus.flush) begin
          drop_d = 1'b1;
        end
        // A flush seen during the transfer discards the block; the CPU simply re-misses.
        if (!bus.busymem) begin
          install = !drop_q && !bus.flush;
          state_d = REFILL;
        end
      end
      REFILL: begin
        busy    = 1'b1;
        drop_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (install) begin
      lru_d[fill_idx] = ~victim;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      baddr_q <= '0;
      drop_q  <= 1'b0;
      rword_q <= '0;
      lru_q   <= '0;
    end else begin
      state_q <= state_d;
      baddr_q <= baddr_d;
      drop_q  <= drop_d;
      rword_q <= rword_d;
      lru_q   <= lru_d;
    end
  end

  assign bus.readword   = hit ? hit_word : rword_q;
  assign bus.busycache  = busy && !rst;
  assign bus.read       = rd_req;
  assign bus.addressmem = baddr_q;

endmodule
